// File: rtl/ddr_rd_slip_train_if.sv
// ddr_rd_slip_train_if: bundle between the init sequencer, the DDR PHY read lanes and the slip trainer.
// The master modport belongs to the side that issues start and supplies lane words; the slave modport belongs to the trainer.
interface ddr_rd_slip_train_if;
    logic       start;
    logic [7:0] q_0;
    logic [7:0] q_1;
    logic       align_rst_ol;
    logic       align_il;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] slip_cnt;
    logic       lock_lost;

    modport master (
        output start, q_0, q_1,
        input  align_rst_ol, align_il, busy, done, fail, slip_cnt, lock_lost
    );

    modport slave (
        input  start, q_0, q_1,
        output align_rst_ol, align_il, busy, done, fail, slip_cnt, lock_lost
    );
endinterface

// File: rtl/ddr_rd_slip_train.sv
// ddr_rd_slip_train: read-side word-alignment trainer for the x2 DDR IO pair, gsclk domain.
// Define DDR_RD_LOCK_MONITOR_EN to build the post-lock loss-of-lock monitor (lock_lost).
module ddr_rd_slip_train #(
    parameter logic [7:0] TRAIN_PATTERN = 8'h0F,
    parameter int         MATCH_CNT     = 4,
    parameter int         CHECK_CYC     = 16,
    parameter int         SLIP_WAIT     = 8,
    parameter int         RST_CYC       = 4,
    parameter int         MAX_SLIPS     = 8
) (
    input logic                gsclk,
    input logic                rst_n,
    ddr_rd_slip_train_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRST, SETTLE, CHECK, SLIP, WAIT, DONE, FAIL} state_t;

    localparam logic [7:0] RST_LAST   = 8'(RST_CYC - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(SLIP_WAIT - 1);
    localparam logic [7:0] CHECK_LAST = 8'(CHECK_CYC - 1);
    localparam logic [3:0] MATCH_TGT  = 4'(MATCH_CNT);
    localparam logic [3:0] SLIP_MAX   = 4'(MAX_SLIPS);

    state_t     state, next_state;
    logic [7:0] cyc_cnt, cyc_cnt_d;
    logic [3:0] match_cnt, match_cnt_d, match_inc;
    logic [3:0] slip_cnt_q, slip_cnt_d;
    logic       hit, start_ok;
    logic       align_rst_q, align_rst_d;
    logic       align_il_q, align_il_d;
    logic       busy_q, busy_d, done_q, done_d, fail_q, fail_d;

    assign hit       = (bus.q_0 == TRAIN_PATTERN) && (bus.q_1 == TRAIN_PATTERN);
    assign match_inc = hit ? match_cnt + 4'd1 : 4'd0;
    assign start_ok  = (state == IDLE || state == DONE || state == FAIL) && bus.start;

    // Outputs are registered from the next state so the PHY controls never glitch.
    always_ff @(posedge gsclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            match_cnt   <= '0;
            slip_cnt_q  <= '0;
            align_rst_q <= 1'b0;
            align_il_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state       <= next_state;
            cyc_cnt     <= cyc_cnt_d;
            match_cnt   <= match_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            align_rst_q <= align_rst_d;
            align_il_q  <= align_il_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        next_state  = state;
        cyc_cnt_d   = cyc_cnt;
        match_cnt_d = match_cnt;
        case (state)
            IDLE, DONE, FAIL: begin
                if (bus.start) begin
                    next_state = PRST;
                    cyc_cnt_d  = '0;
                end
            end
            PRST: begin
                if (cyc_cnt == RST_LAST) begin
                    next_state = SETTLE;
                    cyc_cnt_d  = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt + 8'd1;
                end
            end
            SETTLE, WAIT: begin
                if (cyc_cnt == WAIT_LAST) begin
                    next_state  = CHECK;
                    cyc_cnt_d   = '0;
                    match_cnt_d = '0;
                end else begin
                    cyc_cnt_d = cyc_cnt + 8'd1;
                end
            end
            CHECK: begin
                // A completed match run wins over window expiry on the same cycle.
                match_cnt_d = match_inc;
                if (match_inc == MATCH_TGT) begin
                    next_state = DONE;
                end else if (cyc_cnt == CHECK_LAST) begin
                    cyc_cnt_d  = '0;
                    next_state = (slip_cnt_q == SLIP_MAX) ? FAIL : SLIP;
                end else begin
                    cyc_cnt_d = cyc_cnt + 8'd1;
                end
            end
            SLIP: begin
                next_state = WAIT;
                cyc_cnt_d  = '0;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        align_rst_d = (next_state == PRST);
        align_il_d  = (next_state == SLIP);
        busy_d      = (next_state == PRST) || (next_state == SETTLE) || (next_state == CHECK) ||
                      (next_state == SLIP) || (next_state == WAIT);
        done_d      = (next_state == DONE);
        fail_d      = (next_state == FAIL);
        slip_cnt_d  = slip_cnt_q;
        if (start_ok) begin
            slip_cnt_d = '0;
        end else if (state == CHECK && next_state == SLIP) begin
            slip_cnt_d = slip_cnt_q + 4'd1;
        end
    end

    assign bus.align_rst_ol = align_rst_q;
    assign bus.align_il     = align_il_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.fail         = fail_q;
    assign bus.slip_cnt     = slip_cnt_q;

`ifdef DDR_RD_LOCK_MONITOR_EN
    logic [3:0] miss_cnt;
    logic       lock_lost_q;

    // Once locked, a full MATCH_CNT run of misses latches lock_lost until the next start.
    always_ff @(posedge gsclk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt    <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            if (start_ok) begin
                lock_lost_q <= 1'b0;
            end
            if (state == DONE && next_state == DONE) begin
                if (hit) begin
                    miss_cnt <= '0;
                end else if (miss_cnt != MATCH_TGT) begin
                    miss_cnt <= miss_cnt + 4'd1;
                    if (miss_cnt + 4'd1 == MATCH_TGT) begin
                        lock_lost_q <= 1'b1;
                    end
                end
            end else begin
                miss_cnt <= '0;
            end
        end
    end

    assign bus.lock_lost = lock_lost_q;
`else
    assign bus.lock_lost = 1'b0;
`endif
endmodule

// File: tb/tb_ddr_rd_slip_train.sv
// tb_ddr_rd_slip_train: self-checking bench for ddr_rd_slip_train, outcome and latency predicted from the training rules.
// Build with DDR_RD_LOCK_MONITOR_EN defined to expect lock_lost behaviour after lock.
module tb_ddr_rd_slip_train;
    localparam logic [7:0] PAT         = 8'h0F;
    localparam int         MATCH_CNT   = 4;
    localparam int         CHECK_CYC   = 16;
    localparam int         SLIP_WAIT   = 8;
    localparam int         RST_CYC     = 4;
    localparam int         MAX_SLIPS   = 8;
    localparam int         CHECK_START = 1 + RST_CYC + SLIP_WAIT;
    localparam int         SLIP_PERIOD = CHECK_CYC + 1 + SLIP_WAIT;
    localparam int         CYCLE_LIMIT = 600;

    localparam int MODE_ROT   = 0;
    localparam int MODE_WIN   = 1;
    localparam int MODE_CONST = 2;
    localparam int MODE_LANE  = 3;

`ifdef DDR_RD_LOCK_MONITOR_EN
    localparam logic MONITOR = 1'b1;
`else
    localparam logic MONITOR = 1'b0;
`endif

    logic gsclk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int res_cycles, res_pulses, res_rst_cycles, res_overlap, res_long_slip;
    bit res_timeout;

    ddr_rd_slip_train_if bus ();

    ddr_rd_slip_train dut (
        .gsclk (gsclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 gsclk = ~gsclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Number of left rotations bringing w onto the pattern, -1 if none does.
    function automatic int slipsToAlign(input logic [7:0] w);
        logic [7:0] r;
        r = w;
        for (int k = 0; k < 8; k++) begin
            if (r == PAT) return k;
            r = {r[6:0], r[7]};
        end
        return -1;
    endfunction

    // Index of the cycle completing the first run of MATCH_CNT hits, -1 if the window has none.
    function automatic int firstLock(input logic [15:0] v);
        int run;
        run = 0;
        for (int i = 0; i < CHECK_CYC; i++) begin
            run = v[i] ? run + 1 : 0;
            if (run == MATCH_CNT) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] laneWords(input int mode, input logic [7:0] cur, input logic [7:0] word,
                                              input logic [15:0] hitvec, input int cyc, input bit slipped);
        logic [7:0] w;
        case (mode)
            MODE_ROT:   return {cur, cur};
            MODE_CONST: return {word, word};
            MODE_LANE:  return {(slipped ? PAT : word), PAT};
            default: begin
                w = 8'hAA;
                if (slipped) w = PAT;
                else if (cyc >= CHECK_START && cyc < CHECK_START + CHECK_CYC)
                    w = hitvec[cyc - CHECK_START] ? PAT : 8'hAA;
                return {w, w};
            end
        endcase
    endfunction

    // Pulse start and run one training pass, rotating lanes on every observed slip.
    task automatic applyStimulus(input int mode, input logic [7:0] word, input logic [15:0] hitvec,
                                 input int extra_start);
        int         cyc;
        bit         finished, slipped, prev_il;
        logic [7:0] cur;
        logic [15:0] lanes;
        cur = word; slipped = 0; prev_il = 0; cyc = 0; finished = 0;
        res_pulses = 0; res_rst_cycles = 0; res_overlap = 0; res_long_slip = 0;
        @(negedge gsclk);
        lanes = laneWords(mode, cur, word, hitvec, 0, slipped);
        {bus.q_1, bus.q_0} = lanes;
        bus.start = 1'b1;
        while (!finished && cyc < CYCLE_LIMIT) begin
            @(posedge gsclk);
            #1;
            cyc++;
            bus.start = (cyc == extra_start);
            if (bus.align_il) begin
                res_pulses++;
                slipped = 1;
                cur = {cur[6:0], cur[7]};
                if (prev_il) res_long_slip++;
            end
            if (bus.align_rst_ol) res_rst_cycles++;
            if (bus.align_il && bus.align_rst_ol) res_overlap++;
            prev_il = bus.align_il;
            lanes = laneWords(mode, cur, word, hitvec, cyc, slipped);
            {bus.q_1, bus.q_0} = lanes;
            if (cyc == 1) checkOutput("busy_after_start", bus.busy, 1);
            if (bus.done || bus.fail) finished = 1;
        end
        bus.start   = 1'b0;
        res_cycles  = cyc;
        res_timeout = !finished;
    endtask

    task automatic checkRun(input string tag, input bit exp_done, input int exp_slips, input int exp_latency);
        checkOutput({tag, ".timeout"}, res_timeout, 0);
        checkOutput({tag, ".done"}, bus.done, exp_done);
        checkOutput({tag, ".fail"}, bus.fail, !exp_done);
        checkOutput({tag, ".busy"}, bus.busy, 0);
        checkOutput({tag, ".slip_cnt"}, bus.slip_cnt, exp_slips);
        checkOutput({tag, ".latency"}, res_cycles, exp_latency);
        checkOutput({tag, ".slip_pulses"}, res_pulses, exp_slips);
        checkOutput({tag, ".prst_cycles"}, res_rst_cycles, RST_CYC);
        checkOutput({tag, ".pulse_shape"}, res_overlap + res_long_slip, 0);
    endtask

    // Rotation or constant data: predict outcome purely from how many rotations reach the pattern.
    task automatic runWord(input string tag, input int mode, input logic [7:0] word, input int extra_start);
        int s;
        s = slipsToAlign(word);
        applyStimulus(mode, word, 16'h0000, extra_start);
        if (s >= 0 && (mode == MODE_ROT || s == 0) && s <= MAX_SLIPS)
            checkRun(tag, 1'b1, s, CHECK_START + s * SLIP_PERIOD + MATCH_CNT);
        else
            checkRun(tag, 1'b0, MAX_SLIPS, CHECK_START + MAX_SLIPS * SLIP_PERIOD + CHECK_CYC);
    endtask

    task automatic runWindow(input string tag, input logic [15:0] hitvec);
        int i;
        i = firstLock(hitvec);
        applyStimulus(MODE_WIN, 8'hAA, hitvec, 0);
        if (i >= 0) checkRun(tag, 1'b1, 0, CHECK_START + i + 1);
        else        checkRun(tag, 1'b1, 1, CHECK_START + SLIP_PERIOD + MATCH_CNT);
    endtask

    initial begin
        logic [7:0]  w;
        logic [15:0] v;
        int          guard;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.q_0   = 8'hAA;
        bus.q_1   = 8'hAA;
        #12;
        checkOutput("reset_outputs", {bus.align_il, bus.align_rst_ol, bus.busy, bus.done, bus.fail,
                                      bus.lock_lost, bus.slip_cnt}, 0);
        repeat (2) @(negedge gsclk);
        rst_n = 1'b1;
        repeat (2) @(negedge gsclk);
        checkOutput("idle_outputs", {bus.align_il, bus.align_rst_ol, bus.busy, bus.done, bus.fail}, 0);

        $display("[TB] aligned data, with an ignored start while busy");
        runWord("aligned", MODE_ROT, PAT, 6);

        $display("[TB] loss of lock after done");
        bus.q_0 = 8'hAA;
        bus.q_1 = 8'hAA;
        repeat (MATCH_CNT - 1) @(posedge gsclk);
        #1;
        checkOutput("lock_lost_early", bus.lock_lost, 0);
        @(posedge gsclk);
        #1;
        checkOutput("lock_lost", bus.lock_lost, MONITOR);
        checkOutput("done_held", bus.done, 1);

        runWord("rot_e1", MODE_ROT, 8'hE1, 0);
        checkOutput("lock_lost_cleared", bus.lock_lost, 0);
        runWord("wrong_aa", MODE_CONST, 8'hAA, 0);
        runWord("restart_after_fail", MODE_ROT, PAT, 0);

        applyStimulus(MODE_LANE, 8'h1E, 16'h0000, 0);
        checkRun("single_lane", 1'b1, 1, CHECK_START + SLIP_PERIOD + MATCH_CNT);

        runWindow("interrupted", 16'h00F7);
        runWindow("late_run", 16'hF000);

        for (int n = 0; n < 5; n++) begin
            w = PAT;
            for (int r = $urandom_range(0, 7); r > 0; r--) w = {w[0], w[7:1]};
            runWord($sformatf("rand_rot%0d", n), MODE_ROT, w, 0);
        end
        for (int n = 0; n < 4; n++) begin
            v = 16'($urandom());
            runWindow($sformatf("rand_win%0d", n), v);
        end
        do w = 8'($urandom()); while ($countones(w) == 4);
        runWord("rand_wrong", MODE_CONST, w, 0);

        $display("[TB] reset during wait");
        @(negedge gsclk);
        bus.q_0   = 8'hAA;
        bus.q_1   = 8'hAA;
        bus.start = 1'b1;
        @(negedge gsclk);
        bus.start = 1'b0;
        guard = 0;
        while (bus.slip_cnt != 4'd2 && guard < CYCLE_LIMIT) begin
            @(negedge gsclk);
            guard++;
        end
        checkOutput("abort_reach_wait", guard < CYCLE_LIMIT, 1);
        repeat (3) @(posedge gsclk);
        #2;
        checkOutput("abort_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", {bus.align_il, bus.align_rst_ol, bus.busy, bus.done, bus.fail,
                                      bus.lock_lost, bus.slip_cnt}, 0);
        @(negedge gsclk);
        rst_n = 1'b1;
        runWord("after_abort", MODE_ROT, 8'h87, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr_rd_slip_train.md
Name: ddr_rd_slip_train

Overview:
- Read-side training controller that drives the alignment interface of the x2 DDR IO pair and consumes its deserialized 8-bit words.
- Pulses the PHY alignment reset, then checks both lane words (q_0, q_1) against a known training pattern.
- Issues single-cycle align_il slip pulses until both lanes lock, or the slip budget runs out.
- Sits between the DDR PHY wrapper and the memory-controller init sequencer, in the gsclk domain.

Parameters:
- TRAIN_PATTERN, 8'h0F: expected word on each lane when aligned. All 8 rotations must be distinct.
- MATCH_CNT, 4: consecutive matching cycles required to declare lock (1..15).
- CHECK_CYC, 16: cycles in the check window before a slip is issued (MATCH_CNT..255).
- SLIP_WAIT, 8: settle cycles after each slip pulse (1..255).
- RST_CYC, 4: cycles align_rst_ol is held high at training start (1..15).
- MAX_SLIPS, 8: slip budget before failure (1..15).

Ports:
- gsclk, input, 1: system (slow) clock. All logic runs on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle request to begin training.
- q_0, input, 8: deserialized word, lane 0.
- q_1, input, 8: deserialized word, lane 1.
- align_rst_ol, output, 1: alignment reset to the PHY, registered.
- align_il, output, 1: input-gearbox slip pulse, registered.
- busy, output, 1: training in progress.
- done, output, 1: lock achieved. Level, held until the next start.
- fail, output, 1: slip budget exhausted. Level, held until the next start.
- slip_cnt, output, 4: number of slips issued in the current run.
- lock_lost, output, 1: sticky loss-of-lock flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; internal counters 0.
  - Assertion of rst_n low mid-operation aborts immediately.
  - align_il and align_rst_ol deassert asynchronously.
- States: IDLE, PRST, SETTLE, CHECK, SLIP, WAIT, DONE, FAIL.
- IDLE/DONE/FAIL + start:
  - Next cycle enter PRST.
  - Clear done, fail, lock_lost and slip_cnt; set busy.
- start while busy is ignored.
- PRST: align_rst_ol=1 for exactly RST_CYC cycles, then SETTLE.
- SETTLE: SLIP_WAIT cycles with align_rst_ol=0, then CHECK. Match and window counters start cleared.
- CHECK:
  - Each cycle, hit = (q_0==TRAIN_PATTERN) && (q_1==TRAIN_PATTERN).
  - On hit, the match counter increments; on a miss it clears to 0.
  - When the match counter reaches MATCH_CNT: go to DONE (done=1, busy=0). This takes priority over window expiry in the same cycle.
  - Otherwise, after CHECK_CYC cycles in CHECK:
    - If slip_cnt==MAX_SLIPS, go to FAIL (fail=1, busy=0).
    - Else go to SLIP.
- SLIP:
  - align_il=1 for exactly one cycle; slip_cnt increments in the same cycle.
  - Then WAIT.
  - slip_cnt never exceeds MAX_SLIPS and does not wrap.
- WAIT: SLIP_WAIT cycles, then CHECK with the match and window counters cleared.
- align_il and align_rst_ol are never high together and never high outside SLIP/PRST.
- Minimum lock latency with aligned data: start → done is 1+RST_CYC+SLIP_WAIT+MATCH_CNT cycles (17 with defaults).
- done and fail are mutually exclusive.

Optional Feature:
- Macro: DDR_RD_LOCK_MONITOR_EN.
- Defined:
  - In DONE, hit is evaluated every cycle.
  - MATCH_CNT consecutive misses set lock_lost=1 (sticky until next start or reset).
  - done remains 1; no automatic retrain.
- Undefined: lock_lost is tied 0 and no monitor logic is built.

Test Plan:
- Aligned data: q_0=q_1=8'h0F constantly, start pulse → align_rst_ol high for 4 cycles, done=1 at cycle 17, slip_cnt=0, align_il never high.
- Rotated data that becomes aligned after 3 slips: bench rotates both lanes by one on each align_il pulse, starting from 8'hE1 → exactly 3 single-cycle align_il pulses, done=1, slip_cnt=3.
- Wrong data: q_0=q_1=8'hAA always → 8 align_il pulses, then fail=1, busy=0, slip_cnt=8, done=0.
- Single-lane mismatch: q_0=8'h0F, q_1=8'h1E until the first slip, after which q_1=8'h0F → one slip, then done.
- Interrupted match: pattern for 3 cycles, 1 miss, then pattern for 4 → match counter restarts, lock only after the 4-run.
- Abort and restart:
  - rst_n low during WAIT → all outputs 0 immediately.
  - start during busy → ignored.
  - start after fail → slip_cnt cleared, training restarts.
  - With DDR_RD_LOCK_MONITOR_EN: after done, 4 mismatches → lock_lost=1.
